// File: rtl/io_input_cond.sv
// Board input conditioning: 2-flop synchronizers on switches and buttons, per-button debounce with edge pulses and sticky press flags.
// Latency: sw_o follows sw_raw after 2 edges; btn_o follows a held button level after DEB_CYCLES+2 edges.
// Backpressure: none; free-running sampler, every input is consumed every cycle.
module io_input_cond #(
    parameter int DEB_CYCLES     = 500000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sw_raw,
    input  logic [3:0]  btn_raw,
    input  logic [3:0]  btn_evt_clr,
    output logic [31:0] sw_o,
    output logic [3:0]  btn_o,
    output logic [3:0]  btn_press,
    output logic [3:0]  btn_release,
    output logic [3:0]  btn_evt
);

    // One extra bit keeps DEB_CYCLES-1 representable for any legal DEB_CYCLES.
    localparam int            CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    // Buttons ride in the top 4 bits of the shared synchronizer chain.
    logic [35:0]         sync1_q;
    logic [35:0]         sync2_q;
    logic [3:0]          btn_lvl;

    logic [3:0][CW-1:0]  cnt_q;
    logic [3:0][CW-1:0]  cnt_d;
    logic [3:0]          btn_q;
    logic [3:0]          btn_d;
    logic [3:0]          press_q;
    logic [3:0]          press_d;
    logic [3:0]          release_q;
    logic [3:0]          release_d;
    logic [3:0]          evt_q;
    logic [3:0]          evt_d;

    // Two-stage metastability filter on all 36 asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_raw, sw_raw};
            sync2_q <= sync1_q;
        end
    end

    // Polarity fix applied after synchronization so pressed is always 1 internally.
    assign btn_lvl = sync2_q[35:32] ^ {4{BTN_ACTIVE_LOW}};

    // Per-button debounce: count consecutive disagreeing samples, any agreeing sample restarts the count.
    always_comb begin
        cnt_d     = '0;
        btn_d     = btn_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_lvl[i] != btn_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Count stops here, so it can never wrap.
                    btn_d[i]     = ~btn_q[i];
                    press_d[i]   = ~btn_q[i];
                    release_d[i] = btn_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // A press arriving with a clear still leaves the flag set so the event is not lost.
        evt_d = (evt_q & ~btn_evt_clr) | press_d;
    end

    // Debounce state, edge pulses and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            evt_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            evt_q     <= evt_d;
        end
    end

    assign sw_o        = sync2_q[31:0];
    assign btn_o       = btn_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_evt     = evt_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Bench for io_input_cond with DEB_CYCLES=4, active-high buttons.
// Directed scenarios followed by randomized traffic against a queue-based reference model.
// Outputs are compared 1 time unit after every rising edge.
module tb_io_input_cond;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [3:0]  btn_evt_clr;
    logic [31:0] sw_o;
    logic [3:0]  btn_o;
    logic [3:0]  btn_press;
    logic [3:0]  btn_release;
    logic [3:0]  btn_evt;

    io_input_cond #(
        .DEB_CYCLES    (DEB),
        .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .btn_evt_clr(btn_evt_clr),
        .sw_o       (sw_o),
        .btn_o      (btn_o),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_evt    (btn_evt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: raw samples seen at past edges, plus expected outputs.
    logic [31:0] sw_hist[$];
    logic [3:0]  btn_hist[$];
    logic [31:0] m_sw;
    logic [3:0]  m_btn;
    logic [3:0]  m_press;
    logic [3:0]  m_rel;
    logic [3:0]  m_evt;
    int          run[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, update the model from the spec rules, compare every output.
    task automatic step();
        logic [3:0] lvl;
        @(posedge clk);
        if (rst) begin
            sw_hist.delete();
            btn_hist.delete();
            m_sw = '0; m_btn = '0; m_press = '0; m_rel = '0; m_evt = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            // Output after this edge is the raw value sampled one edge earlier (2-edge delay).
            m_sw = (sw_hist.size() >= 1) ? sw_hist[sw_hist.size()-1] : 32'h0;
            // Level judged at this edge is the raw value from two edges back.
            lvl  = (btn_hist.size() >= 2) ? btn_hist[btn_hist.size()-2] : 4'h0;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < 4; i++) begin
                if (lvl[i] != m_btn[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        m_btn[i] = lvl[i];
                        m_press[i] = lvl[i];
                        m_rel[i]   = ~lvl[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_evt = (m_evt & ~btn_evt_clr) | m_press;
            sw_hist.push_back(sw_raw);
            btn_hist.push_back(btn_raw);
            if (sw_hist.size() > 2) void'(sw_hist.pop_front());
            if (btn_hist.size() > 2) void'(btn_hist.pop_front());
        end
        #1;
        chk("sw_o",        sw_o,                 m_sw);
        chk("btn_o",       32'(btn_o),           32'(m_btn));
        chk("btn_press",   32'(btn_press),       32'(m_press));
        chk("btn_release", 32'(btn_release),     32'(m_rel));
        chk("btn_evt",     32'(btn_evt),         32'(m_evt));
        @(negedge clk);
    endtask

    initial begin
        int rise;
        int cnt;
        rst         = 1'b0;
        sw_raw      = 32'hFFFF_FFFF;
        btn_raw     = 4'hF;
        btn_evt_clr = 4'h0;
        m_sw = '0; m_btn = '0; m_press = '0; m_rel = '0; m_evt = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        #2 rst = 1'b1;

        // Reset holds everything at zero despite all-ones inputs.
        repeat (3) step();
        chk("rst_hold", {sw_o[3:0], btn_o, btn_press, btn_release, btn_evt}, 32'h0);

        // Release reset with a new switch word and button 0 pressed.
        rst     = 1'b0;
        sw_raw  = 32'd123456;
        btn_raw = 4'b0001;
        step();
        chk("sw_edge1", sw_o, 32'h0);
        step();
        chk("sw_edge2", sw_o, 32'd123456);
        rise = 0;
        for (int k = 3; k <= 12; k++) begin
            step();
            if (rise == 0 && btn_o[0]) begin
                rise = k;
                chk("b0_press_pulse", 32'(btn_press[0]), 32'd1);
            end
        end
        chk("b0_latency", rise, 6);
        chk("b0_evt_held", 32'(btn_evt[0]), 32'd1);
        btn_evt_clr = 4'b0001;
        step();
        btn_evt_clr = 4'b0000;
        chk("b0_evt_cleared", 32'(btn_evt[0]), 32'd0);

        // Button 1: a 3-long high run is too short, then a held high rises once.
        cnt = 0;
        btn_raw[1] = 1'b1; step(); cnt += int'(btn_press[1]);
        step(); cnt += int'(btn_press[1]);
        step(); cnt += int'(btn_press[1]);
        btn_raw[1] = 1'b0; step(); cnt += int'(btn_press[1]);
        chk("b1_short_run", 32'(btn_o[1]), 32'd0);
        btn_raw[1] = 1'b1;
        rise = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            cnt += int'(btn_press[1]);
            if (rise == 0 && btn_o[1]) rise = k;
        end
        chk("b1_latency", rise, 6);
        chk("b1_press_count", cnt, 1);

        // Button 2: clear coinciding with the press edge loses to the set.
        btn_raw[2] = 1'b1;
        repeat (5) step();
        btn_evt_clr = 4'b0100;
        step();
        btn_evt_clr = 4'b0000;
        chk("b2_press_edge", 32'(btn_press[2]), 32'd1);
        chk("b2_evt_set_wins", 32'(btn_evt[2]), 32'd1);
        step();
        chk("b2_evt_kept", 32'(btn_evt[2]), 32'd1);
        btn_evt_clr = 4'b0100;
        step();
        btn_evt_clr = 4'b0000;
        chk("b2_evt_later_clr", 32'(btn_evt[2]), 32'd0);

        // Button 3: reset mid-count discards progress.
        btn_raw[3] = 1'b1;
        repeat (3) step();
        chk("b3_not_yet", 32'(btn_o[3]), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_btn", 32'(btn_o), 32'd0);
        chk("async_rst_sw", sw_o, 32'd0);
        step();
        rst  = 1'b0;
        rise = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rise == 0 && btn_o[3]) rise = k;
        end
        chk("b3_latency_after_rst", rise, 6);
        chk("b3_evt_after_press", 32'(btn_evt[3]), 32'd1);
        btn_raw[3] = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            cnt += int'(btn_release[3]);
        end
        chk("b3_release_count", cnt, 1);
        chk("b3_evt_after_release", 32'(btn_evt[3]), 32'd1);

        // Randomized traffic: sticky-ish buttons, random clears, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            sw_raw = $urandom;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
            btn_evt_clr = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
